serial_alu: RTL
===============

Name: serial_alu

Overview:
- Multi-cycle, parametrised N-bit ALU; successor to the single-bit ALU slice.
- Processes DIGIT bits per clock, LSB first, with a carry held in a flop between cycles. This trades latency for area.
- Uses the same 3-bit opcode map as the 1-bit slice. Adds SLT, status flags and a valid/ready handshake on input and output.
- Sits between the register-read stage and writeback of the lab CPU datapath.

Parameters:
- WIDTH, 32, operand/result width in bits.
- DIGIT, 1, bits processed per cycle. Must divide WIDTH; legal values 1, 2, 4, 8.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  operands and op present.
- in_ready  output  1  block can accept an operation.
- a  input  WIDTH  operand A.
- b  input  WIDTH  operand B.
- op  input  3  000 ADD, 001 SUB, 010 XOR, 011 SLT, 100 AND, 101 NAND, 110 NOR, 111 OR.
- out_valid  output  1  result and flags valid.
- out_ready  input  1  consumer accepts the result.
- result  output  WIDTH  operation result.
- carry  output  1  carry out (ADD); no-borrow (SUB).
- overflow  output  1  signed overflow (ADD/SUB).
- zero  output  1  result == 0.

Behaviour:
- Reset (rst_n low, asynchronous):
  - State goes to IDLE.
  - in_ready=1; out_valid=0.
  - result, carry, overflow, zero all 0.
  - Operand, counter and carry flops cleared.
  - Reset mid-RUN or mid-DONE discards the operation; no output is produced.
- States: IDLE, RUN, DONE. Let N = WIDTH/DIGIT.
- IDLE:
  - in_ready=1, out_valid=0.
  - On a clock edge with in_valid=1: latch a, b and op; set counter=0.
  - Serial carry init = 1 for SUB/SLT, 0 otherwise. B is inverted for SUB/SLT.
  - Next state RUN.
- RUN:
  - in_ready=0.
  - Each cycle: compute DIGIT result bits from the low DIGIT bits of the A/B shift registers and the held carry.
  - Shift those bits into the top of the result register; shift A and B right by DIGIT; update carry; increment counter.
  - After cycle N, go to DONE.
- Latency: out_valid rises exactly N cycles after the accepting edge.
  - WIDTH=32, DIGIT=1 gives 32 cycles.
  - WIDTH=32, DIGIT=4 gives 8 cycles.
- Flag and result computation, performed on the final RUN cycle from the full-width result:
  - overflow = carry into MSB XOR carry out of MSB, for ADD/SUB.
  - carry = final carry out, for ADD/SUB. For SUB, carry=1 iff a >= b unsigned.
  - SLT: result = zero-extended (sign of a-b XOR overflow), i.e. signed a < b. carry=0 and overflow=0 for SLT.
  - XOR/AND/NAND/NOR/OR: bitwise; carry=0, overflow=0.
  - zero = (result == 0) for every op.
- DONE:
  - out_valid=1; result and flags held stable.
  - in_valid is ignored and in_ready=0.
  - On an edge with out_ready=1: go to IDLE, and out_valid falls after that edge.
  - No same-cycle accept of a new op in DONE; the next op is accepted earliest in the cycle after returning to IDLE.
  - Backpressure: out_ready may stay low indefinitely; outputs do not change.
- Inputs a, b and op may change freely after the accepting edge without affecting the result.
- Arithmetic wraps modulo 2^WIDTH.

Test Plan:
- WIDTH=8, DIGIT=1, ADD 0x7F+0x01 -> result 0x80, overflow=1, carry=0, zero=0; out_valid exactly 8 cycles after accept.
- WIDTH=8, DIGIT=2, SUB 0x05-0x05 -> result 0x00, zero=1, carry=1, overflow=0; latency 4 cycles. SUB 0x03-0x05 -> result 0xFE, carry=0.
- WIDTH=8, DIGIT=4, SLT a=0x80 (-128), b=0x01 -> result 0x01. SLT a=0x01, b=0x80 -> result 0x00, zero=1.
- WIDTH=32, DIGIT=1, logic ops with a=0xF0F0F0F0, b=0xFF00FF00 -> results:
  - XOR 0x0FF00FF0
  - AND 0xF000F000
  - NAND 0x0FFF0FFF
  - NOR 0x000F000F
  - OR 0xFFF0FFF0
  - carry=overflow=0 for each.
- Backpressure: hold out_ready=0 for 20 cycles after out_valid with in_valid=1 and changing a/b -> result stable, in_ready=0. Then out_ready=1 for one cycle -> IDLE, in_ready=1 next cycle.
- Assert rst_n low asynchronously mid-RUN of ADD 0xFF+0x01 -> outputs cleared immediately, in_ready=1, no out_valid. Then ADD 0x02+0x03 -> result 0x05.

Source files
------------

// File: rtl/serial_alu.sv
// Digit-serial N-bit ALU: DIGIT bits per clock, LSB first, carry held in a flop.
// Valid/ready handshake on both sides; result and flags held until consumed.
module serial_alu #(
    parameter int WIDTH = 32,
    parameter int DIGIT = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [2:0]       op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             carry,
    output logic             overflow,
    output logic             zero
);

    localparam int N  = WIDTH / DIGIT;
    localparam int CW = (N > 1) ? $clog2(N) : 1;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    localparam logic [2:0] OP_ADD  = 3'b000;
    localparam logic [2:0] OP_SUB  = 3'b001;
    localparam logic [2:0] OP_XOR  = 3'b010;
    localparam logic [2:0] OP_SLT  = 3'b011;
    localparam logic [2:0] OP_AND  = 3'b100;
    localparam logic [2:0] OP_NAND = 3'b101;
    localparam logic [2:0] OP_NOR  = 3'b110;
    localparam logic [2:0] OP_OR   = 3'b111;

    logic [1:0]       state;
    logic [WIDTH-1:0] a_sr;
    logic [WIDTH-1:0] b_sr;
    logic [WIDTH-1:0] res_sr;
    logic [2:0]       op_q;
    logic [CW-1:0]    cnt;
    logic             cy;

    logic [DIGIT-1:0] da;
    logic [DIGIT-1:0] db;
    logic [DIGIT-1:0] dout;
    logic [DIGIT:0]   dsum;
    logic [WIDTH-1:0] res_next;
    logic [WIDTH-1:0] res_fin;
    logic             sub_in;
    logic             is_arith;
    logic             is_slt;
    logic             cout;
    logic             cmsb;
    logic             dovf;
    logic             last;

    assign sub_in   = (op == OP_SUB) || (op == OP_SLT);
    assign is_arith = (op_q == OP_ADD) || (op_q == OP_SUB);
    assign is_slt   = (op_q == OP_SLT);

    assign da   = a_sr[DIGIT-1:0];
    assign db   = b_sr[DIGIT-1:0];
    assign dsum = {1'b0, da} + {1'b0, db} + {{DIGIT{1'b0}}, cy};

    // Carry into the digit's top bit recovered from the sum bit and its inputs.
    assign cout = dsum[DIGIT];
    assign cmsb = dsum[DIGIT-1] ^ da[DIGIT-1] ^ db[DIGIT-1];
    assign dovf = cout ^ cmsb;
    assign last = (cnt == CW'(N - 1));

    always_comb begin
        dout = dsum[DIGIT-1:0];
        case (op_q)
            OP_XOR:  dout = da ^ db;
            OP_AND:  dout = da & db;
            OP_NAND: dout = ~(da & db);
            OP_NOR:  dout = ~(da | db);
            OP_OR:   dout = da | db;
            default: dout = dsum[DIGIT-1:0];
        endcase
    end

    generate
        if (N == 1) begin : g_one
            assign res_next = dout;
        end else begin : g_many
            assign res_next = {dout, res_sr[WIDTH-1:DIGIT]};
        end
    endgenerate

    assign res_fin = is_slt ?
        {{(WIDTH-1){1'b0}}, dsum[DIGIT-1] ^ dovf} : res_next;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            a_sr     <= '0;
            b_sr     <= '0;
            res_sr   <= '0;
            op_q     <= '0;
            cnt      <= '0;
            cy       <= 1'b0;
            carry    <= 1'b0;
            overflow <= 1'b0;
            zero     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        a_sr  <= a;
                        b_sr  <= sub_in ? ~b : b;
                        op_q  <= op;
                        cnt   <= '0;
                        cy    <= sub_in;
                        state <= RUN;
                    end
                end
                RUN: begin
                    a_sr <= a_sr >> DIGIT;
                    b_sr <= b_sr >> DIGIT;
                    cy   <= cout;
                    cnt  <= cnt + CW'(1);
                    if (last) begin
                        res_sr   <= res_fin;
                        carry    <= is_arith & cout;
                        overflow <= is_arith & dovf;
                        zero     <= (res_fin == '0);
                        state    <= DONE;
                    end else begin
                        res_sr <= res_next;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);
    assign result    = res_sr;

endmodule
